// File: rtl/frankie_pkg.sv
// Shared definitions for the Frankie fetch path: PC source encodings,
// RA source selects, IR field positions and default widths.
package frankie_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_IMM_W  = 10;

    // IR field positions
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 11;
    localparam int FLAG_BIT = 10;

    // Next-PC select driven by the control unit
    typedef enum logic [2:0] {
        PC_INC     = 3'b000,  // sequential fetch
        PC_REL     = 3'b001,  // jimm@, jfnc@
        PC_ABS     = 3'b010,  // jimm, jfnc
        PC_RA      = 3'b011,  // jret
        PC_ACC     = 3'b100,  // jacc
        PC_ACC_REL = 3'b101,  // jacc@
        PC_CMP_ABS = 3'b110,  // jcmp
        PC_CMP_REL = 3'b111   // jcmp@
    } pc_src_e;

    // RA load source
    localparam logic RA_SRC_MEM = 1'b0;
    localparam logic RA_SRC_PC  = 1'b1;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection. Also reports whether the selected
// value is a real redirect (non-sequential and not a failed compare).
module pc_next_mux
    import frankie_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int IMM_W  = DEFAULT_IMM_W
) (
    input  logic [DATA_W-1:0] pc,
    input  pc_src_e           pc_src,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] mary,
    input  logic [DATA_W-1:0] ra,
    input  logic              comp,
    output logic [DATA_W-1:0] next_pc,
    output logic              taken
);

    logic [DATA_W-1:0] pc_inc;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic              cmp_fail;

    assign pc_inc   = pc + DATA_W'(1);
    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm};

    // Select the candidate PC; additions wrap silently at DATA_W bits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_pc  = pc_inc;
        cmp_fail = 1'b0;
        case (pc_src)
            PC_INC:     next_pc = pc_inc;
            PC_REL:     next_pc = pc + imm_sext;
            PC_ABS:     next_pc = imm_zext;
            PC_RA:      next_pc = ra;
            PC_ACC:     next_pc = mary;
            PC_ACC_REL: next_pc = pc + mary;
            PC_CMP_ABS: begin
                next_pc  = comp ? imm_zext : pc;
                cmp_fail = !comp;
            end
            PC_CMP_REL: begin
                next_pc  = comp ? (pc + imm_sext) : pc;
                cmp_fail = !comp;
            end
            default:    next_pc = pc_inc;
        endcase
    end

    // A failed compare holds pc, which differs from pc+1 but is not a jump.
    assign taken = (pc_src != PC_INC) && !cmp_fail && (next_pc != pc_inc);

endmodule

// File: rtl/fetch_unit.sv
// Frankie fetch unit: PC, IR, RA and Comp registers plus IR decode.
// Optional macro FETCH_TRACE_EN adds a saturating jump_count output.
module fetch_unit
    import frankie_pkg::*;
#(
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter int                IMM_W    = DEFAULT_IMM_W,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              PCWrite,
    input  logic [2:0]        PCSrc,
    input  logic              InstWrite,
    input  logic              RAWrite,
    input  logic              RASrc,
    input  logic              CompWrite,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mary,
    input  logic [DATA_W-1:0] shelley,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] ra,
    output logic              comp,
    output logic [4:0]        OPCODE,
    output logic              flagbit,
    output logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] imm_sext,
    output logic              jump_taken
`ifdef FETCH_TRACE_EN
    ,
    output logic [15:0]       jump_count
`endif
);

    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] next_pc;
    logic              taken;

    // Shelley and the upper ALU bits are not needed by the fetch path.
    logic unused_inputs;
    assign unused_inputs = ^{shelley, alu_result[DATA_W-1:1]};

    pc_next_mux #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_pc_next_mux (
        .pc      (pc),
        .pc_src  (pc_src_e'(PCSrc)),
        .imm     (imm),
        .mary    (mary),
        .ra      (ra),
        .comp    (comp),
        .next_pc (next_pc),
        .taken   (taken)
    );

    // PC register and registered jump indicator.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            pc         <= RESET_PC;
            jump_taken <= 1'b0;
        end else begin
            if (PCWrite) pc <= next_pc;
            jump_taken <= PCWrite && taken;
        end
    end

    // Instruction register, loaded in the Decode cycle.
    always_ff @(posedge CLK) begin
        if (Reset)          ir <= '0;
        else if (InstWrite) ir <= mem_rdata;
    end

    // Return address; pc here is the pre-jump value when jfnc also writes PC.
    always_ff @(posedge CLK) begin
        if (Reset)        ra <= '0;
        else if (RAWrite) ra <= (RASrc == RA_SRC_PC) ? pc : mem_rdata;
    end

    // Comparison flag; a same-cycle jcmp sees the old value.
    always_ff @(posedge CLK) begin
        if (Reset)          comp <= 1'b0;
        else if (CompWrite) comp <= alu_result[0];
    end

    // Decode fields are the only outputs combinational from registers' contents.
    assign OPCODE   = ir[OPC_MSB:OPC_LSB];
    assign flagbit  = ir[FLAG_BIT];
    assign imm      = ir[IMM_W-1:0];
    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

`ifdef FETCH_TRACE_EN
    // Count taken jumps in step with jump_taken, saturating at all-ones.
    always_ff @(posedge CLK) begin
        if (Reset)
            jump_count <= '0;
        else if (PCWrite && taken && (jump_count != 16'hFFFF))
            jump_count <= jump_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of vectors applied in order,
// expected state queued at drive time and compared after each edge.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset, PCWrite, InstWrite, RAWrite, RASrc, CompWrite;
    logic [2:0]  PCSrc;
    logic [15:0] mem_rdata, alu_result, mary, shelley;
    logic [15:0] pc, ra, imm_sext;
    logic        comp, flagbit, jump_taken;
    logic [4:0]  OPCODE;
    logic [9:0]  imm;
`ifdef FETCH_TRACE_EN
    logic [15:0] jump_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .PCWrite    (PCWrite),
        .PCSrc      (PCSrc),
        .InstWrite  (InstWrite),
        .RAWrite    (RAWrite),
        .RASrc      (RASrc),
        .CompWrite  (CompWrite),
        .mem_rdata  (mem_rdata),
        .alu_result (alu_result),
        .mary       (mary),
        .shelley    (shelley),
        .pc         (pc),
        .ra         (ra),
        .comp       (comp),
        .OPCODE     (OPCODE),
        .flagbit    (flagbit),
        .imm        (imm),
        .imm_sext   (imm_sext),
        .jump_taken (jump_taken)
`ifdef FETCH_TRACE_EN
        ,
        .jump_count (jump_count)
`endif
    );

    typedef struct {
        logic        rst, pcw;
        logic [2:0]  src;
        logic        iw, raw, ras, cw;
        logic [15:0] md, alu, mry;
        logic [15:0] e_pc, e_ra;
        logic        e_comp, e_jt;
        logic [15:0] e_ir, e_sext;
    } vec_t;

    vec_t exp_q[$];

    function automatic vec_t mk(
        input logic rst, input logic pcw, input logic [2:0] src, input logic iw,
        input logic raw, input logic ras, input logic cw,
        input logic [15:0] md, input logic [15:0] alu, input logic [15:0] mry,
        input logic [15:0] e_pc, input logic [15:0] e_ra, input logic e_comp,
        input logic e_jt, input logic [15:0] e_ir, input logic [15:0] e_sext);
        vec_t v;
        v.rst = rst; v.pcw = pcw; v.src = src; v.iw = iw; v.raw = raw;
        v.ras = ras; v.cw = cw; v.md = md; v.alu = alu; v.mry = mry;
        v.e_pc = e_pc; v.e_ra = e_ra; v.e_comp = e_comp; v.e_jt = e_jt;
        v.e_ir = e_ir; v.e_sext = e_sext;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        Reset = v.rst; PCWrite = v.pcw; PCSrc = v.src; InstWrite = v.iw;
        RAWrite = v.raw; RASrc = v.ras; CompWrite = v.cw;
        mem_rdata = v.md; alu_result = v.alu; mary = v.mry;
        exp_q.push_back(v);
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check({tag, " pc"},      pc,         e.e_pc);
        check({tag, " ra"},      ra,         e.e_ra);
        check({tag, " comp"},    comp,       e.e_comp);
        check({tag, " jump"},    jump_taken, e.e_jt);
        check({tag, " opcode"},  OPCODE,     e.e_ir[15:11]);
        check({tag, " flagbit"}, flagbit,    e.e_ir[10]);
        check({tag, " imm"},     imm,        e.e_ir[9:0]);
        check({tag, " sext"},    imm_sext,   e.e_sext);
    endtask

    vec_t vecs[28];

    initial begin
        shelley = 16'h5A5A;
        //            rst pcw src iw raw ras cw md        alu       mary      e_pc      e_ra      cmp jt e_ir      e_sext
        vecs[0]  = mk(1, 0, 3'd0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        vecs[1]  = mk(0, 1, 3'd0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        vecs[2]  = mk(0, 0, 3'd0, 1, 0, 0, 0, 16'h9C05, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 0, 0, 16'h9C05, 16'h0005);
        vecs[3]  = mk(0, 1, 3'd0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 0, 0, 16'h9C05, 16'h0005);
        vecs[4]  = mk(0, 0, 3'd0, 1, 0, 0, 0, 16'h9C05, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 0, 0, 16'h9C05, 16'h0005);
        vecs[5]  = mk(0, 1, 3'd0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'h0000, 0, 0, 16'h9C05, 16'h0005);
        vecs[6]  = mk(0, 0, 3'd0, 1, 0, 0, 0, 16'h9C05, 16'h0000, 16'h0000, 16'h0003, 16'h0000, 0, 0, 16'h9C05, 16'h0005);
        // jacc to 0x0010, then load imm 0x3FE and jimm@ backwards by 2
        vecs[7]  = mk(0, 1, 3'd4, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0010, 16'h0010, 16'h0000, 0, 1, 16'h9C05, 16'h0005);
        vecs[8]  = mk(0, 0, 3'd0, 1, 0, 0, 0, 16'h03FE, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 0, 0, 16'h03FE, 16'hFFFE);
        vecs[9]  = mk(0, 1, 3'd1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h000E, 16'h0000, 0, 1, 16'h03FE, 16'hFFFE);
        vecs[10] = mk(0, 0, 3'd0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h000E, 16'h0000, 0, 0, 16'h03FE, 16'hFFFE);
        // InstWrite with PCWrite together, then jcmp not taken / same-cycle compare / taken
        vecs[11] = mk(0, 1, 3'd0, 1, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 16'h000F, 16'h0000, 0, 0, 16'h0040, 16'h0040);
        vecs[12] = mk(0, 1, 3'd6, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h000F, 16'h0000, 0, 0, 16'h0040, 16'h0040);
        vecs[13] = mk(0, 1, 3'd6, 0, 0, 0, 1, 16'h0000, 16'h0001, 16'h0000, 16'h000F, 16'h0000, 1, 0, 16'h0040, 16'h0040);
        vecs[14] = mk(0, 1, 3'd6, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 16'h0000, 1, 1, 16'h0040, 16'h0040);
        vecs[15] = mk(0, 0, 3'd0, 0, 0, 0, 1, 16'h0000, 16'hFFFE, 16'h0000, 16'h0040, 16'h0000, 0, 0, 16'h0040, 16'h0040);
        // jfnc from 0x0021 to 0x0100, then jret, then RA from memory
        vecs[16] = mk(0, 1, 3'd4, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0021, 16'h0021, 16'h0000, 0, 1, 16'h0040, 16'h0040);
        vecs[17] = mk(0, 0, 3'd0, 1, 0, 0, 0, 16'h0100, 16'h0000, 16'h0000, 16'h0021, 16'h0000, 0, 0, 16'h0100, 16'h0100);
        vecs[18] = mk(0, 1, 3'd2, 0, 1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0021, 0, 1, 16'h0100, 16'h0100);
        vecs[19] = mk(0, 1, 3'd3, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0021, 16'h0021, 0, 1, 16'h0100, 16'h0100);
        vecs[20] = mk(0, 0, 3'd0, 0, 1, 0, 0, 16'hBEEF, 16'h0000, 16'h0000, 16'h0021, 16'hBEEF, 0, 0, 16'h0100, 16'h0100);
        // jacc@, jacc landing on pc+1 (not a jump), jcmp@ not taken
        vecs[21] = mk(0, 1, 3'd5, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0003, 16'h0024, 16'hBEEF, 0, 1, 16'h0100, 16'h0100);
        vecs[22] = mk(0, 1, 3'd4, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0025, 16'h0025, 16'hBEEF, 0, 0, 16'h0100, 16'h0100);
        vecs[23] = mk(0, 1, 3'd7, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0025, 16'hBEEF, 0, 0, 16'h0100, 16'h0100);
        // PC wrap from 0xFFFF
        vecs[24] = mk(0, 1, 3'd4, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hBEEF, 0, 1, 16'h0100, 16'h0100);
        vecs[25] = mk(0, 1, 3'd0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 0, 0, 16'h0100, 16'h0100);
        // Reset mid-instruction with every enable active
        vecs[26] = mk(0, 1, 3'd4, 0, 0, 0, 1, 16'h0000, 16'h0001, 16'h0050, 16'h0050, 16'hBEEF, 1, 1, 16'h0100, 16'h0100);
        vecs[27] = mk(1, 1, 3'd4, 1, 1, 1, 1, 16'hFFFF, 16'h0001, 16'h1234, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);

        for (int i = 0; i < 28; i++)
            apply(vecs[i], $sformatf("v%0d", i));

        // jcmp@ taken with a negative offset that wraps below zero
        apply(mk(0, 0, 3'd0, 1, 0, 0, 0, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0200, 16'hFE00), "h0");
        apply(mk(0, 0, 3'd0, 0, 0, 0, 1, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h0200, 16'hFE00), "h1");
        apply(mk(0, 1, 3'd7, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'hFE00, 16'h0000, 1, 1, 16'h0200, 16'hFE00), "h2");
        apply(mk(0, 0, 3'd0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'hFE00, 16'h0000, 1, 0, 16'h0200, 16'hFE00), "h3");

`ifdef FETCH_TRACE_EN
        // Saturation: jacc to 0x0100 every cycle is always a taken jump.
        apply(mk(1, 0, 3'd0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000), "t0");
        check("count reset", jump_count, 16'h0000);
        Reset = 1'b0; PCWrite = 1'b1; PCSrc = 3'd4; mary = 16'h0100;
        for (int n = 0; n < 65534; n++) @(posedge CLK);
        #1;
        check("count preload", jump_count, 16'hFFFE);
        for (int n = 0; n < 3; n++) @(posedge CLK);
        #1;
        check("count sat", jump_count, 16'hFFFF);
        check("count sat jump", jump_taken, 1'b1);
        PCWrite = 1'b0;
        for (int n = 0; n < 2; n++) @(posedge CLK);
        #1;
        check("count hold", jump_count, 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Upstream/downstream neighbour of the Frankie control unit. Owns the PC, the instruction register (IR), the return-address register (RA) and the comparison flag (Comp).
- Decodes the IR into OPCODE, flagbit and the immediate, which drive the control unit.
- Consumes the control unit's PCWrite/PCSrc, InstWrite, RAWrite/RASrc and CompWrite strobes.

Parameters:
- DATA_W, 16, datapath and PC width
- IMM_W, 10, immediate field width (IR[IMM_W-1:0])
- RESET_PC, 16'h0000, PC value after reset

Ports:
- CLK  in  1  clock, all state changes on posedge
- Reset  in  1  reset: synchronous, active-high; clock CLK
- PCWrite  in  1  PC load enable
- PCSrc  in  3  next-PC select
- InstWrite  in  1  IR load enable
- RAWrite  in  1  RA load enable
- RASrc  in  1  RA source: 0 = mem_rdata, 1 = PC
- CompWrite  in  1  Comp load enable
- mem_rdata  in  DATA_W  memory read data (instruction or popped word)
- alu_result  in  DATA_W  ALU output; bit 0 is the compare result
- mary  in  DATA_W  Mary accumulator value
- shelley  in  DATA_W  Shelley register value
- pc  out  DATA_W  current PC (instruction memory address)
- ra  out  DATA_W  RA register
- comp  out  1  Comp flag
- OPCODE  out  5  IR[15:11]
- flagbit  out  1  IR[10]
- imm  out  IMM_W  IR[IMM_W-1:0]
- imm_sext  out  DATA_W  imm sign-extended
- jump_taken  out  1  1-cycle pulse when the PC loads a non-sequential value

Behaviour:
- Reset (synchronous): pc=RESET_PC, IR=0 (OPCODE=0, flagbit=0, imm=0), ra=0, comp=0, jump_taken=0. Reset has priority over all enables, including mid-instruction in any control state.
- Word-addressed PC; instruction is 16 bits, one per address.
- The Fetch cycle issues PCWrite with PCSrc=000: pc <= pc+1. The memory returns the instruction at the old pc. The Decode cycle asserts InstWrite, and IR <= mem_rdata. OPCODE/flagbit/imm are combinational from IR, valid from the cycle after InstWrite.
- Because of the above, pc already points to the next instruction in the Third/Fourth states. Relative offsets use that value.
- Next-PC on PCWrite=1, with all arithmetic mod 2^DATA_W and wrap-around silent (16'hFFFF+1 = 0):
  - 000: pc+1
  - 001: pc+imm_sext (jimm@, jfnc@)
  - 010: zero-extended imm (jimm, jfnc)
  - 011: ra (jret)
  - 100: mary (jacc)
  - 101: pc+mary (jacc@)
  - 110: if comp then zero-extended imm, else pc unchanged (jcmp)
  - 111: if comp then pc+imm_sext, else pc unchanged (jcmp@)
- PCWrite=0: pc holds.
- jump_taken: registered. Goes to 1 for exactly one cycle after any PCWrite with PCSrc!=000 whose new pc differs from pc+1. A not-taken jcmp gives 0.
- RAWrite=1: ra <= (RASrc ? pc : mem_rdata). With RAWrite and PCWrite in the same cycle (jfnc), ra takes the pre-jump pc.
- CompWrite=1: comp <= alu_result[0].
- Same-cycle CompWrite and PCSrc 110/111: the branch uses the old (registered) comp.
- InstWrite with PCWrite in the same cycle: both take effect, independently.
- No outputs are combinational from the inputs, except the IR-derived decode fields.

Optional Feature:
- Macro FETCH_TRACE_EN.
- Defined: adds output jump_count[15:0].
  - Cleared on Reset.
  - Increments on every cycle where jump_taken is about to assert.
  - Saturates at 16'hFFFF with no wrap.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package frankie_pkg:
  - PCSrc encoding constants (PC_INC, PC_REL, PC_ABS, PC_RA, PC_ACC, PC_ACC_REL, PC_CMP_ABS, PC_CMP_REL)
  - RASrc constants
  - IR field positions (OPC_MSB=15, OPC_LSB=11, FLAG_BIT=10)
  - DATA_W/IMM_W defaults
- One combinational sub-module, pc_next_mux. Inputs: pc, PCSrc, imm, mary, ra, comp. Outputs: next_pc and a taken flag. The registers stay in fetch_unit.

Test Plan:
- Reset then 3 fetch/decode pairs with mem_rdata=16'h9C05 -> pc 0->1->2->3; OPCODE=5'b10011, flagbit=1, imm=10'h005, imm_sext=16'h0005.
- pc=16'h0010, IR imm=10'h3FE, PCSrc=001 -> pc=16'h000E; jump_taken pulses 1 cycle.
- comp=0, PCSrc=110, imm=10'h040 -> pc unchanged, jump_taken=0. Then CompWrite with alu_result=1 and the jcmp repeated -> pc=16'h0040.
- jfnc: pc=16'h0021, RAWrite=1, RASrc=1, PCWrite=1, PCSrc=010, imm=10'h100 -> ra=16'h0021, pc=16'h0100. Then PCSrc=011 -> pc=16'h0021.
- pc=16'hFFFF with PCSrc=000 -> pc=16'h0000. Separately, Reset asserted during the Fourth state with PCWrite=1 -> pc=RESET_PC, IR=0, comp=0 next edge.
- With FETCH_TRACE_EN: preload 16'hFFFE jumps, 3 more taken jumps -> jump_count=16'hFFFF and holds.
